// File: rtl/bb_bus_pkg.sv
// rtl/bb_bus_pkg.sv - shared constants and slave state encoding for the bit-serial bus
package bb_bus_pkg;

    localparam int BUS_ADDR_BITS = 16;
    localparam int BUS_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WDATA  = 3'd2,
        MEM_WR = 3'd3,
        MEM_RD = 3'd4,
        SPLIT  = 3'd5,
        RDATA  = 3'd6
    } slave_state_e;

endpackage

// File: rtl/bb_slave_bram.sv
// rtl/bb_slave_bram.sv - byte-wide local memory with a run-time selectable read latency
module bb_slave_bram
    import bb_bus_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [7:0]               rd_latency,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [BUS_DATA_BITS-1:0] wdata,
    output logic [BUS_DATA_BITS-1:0] rdata,
    output logic                     rvalid
);

    logic [BUS_DATA_BITS-1:0] mem_q [2**ADDR_W];
    logic                     busy_q, busy_d;
    logic [7:0]               lat_q, lat_d;
    logic [BUS_DATA_BITS-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Data is sampled at the request; rvalid is delayed by the remaining latency.
    always_comb begin
        busy_d  = busy_q;
        lat_d   = lat_q;
        rdata_d = rdata_q;
        if (busy_q) begin
            if (lat_q == 8'd0) begin
                busy_d = 1'b0;
            end else begin
                lat_d = lat_q - 8'd1;
            end
        end
        if (re) begin
            busy_d  = 1'b1;
            lat_d   = (rd_latency == 8'd0) ? 8'd0 : rd_latency - 8'd1;
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q  <= 1'b0;
            lat_q   <= 8'd0;
            rdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
        end
    end

    assign rvalid = busy_q && (lat_q == 8'd0);
    assign rdata  = rdata_q;

endmodule

// File: rtl/bb_slave_port.sv
// rtl/bb_slave_port.sv - bit-serial bus target endpoint issuing one local memory access per transaction
module bb_slave_port
    import bb_bus_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int SPLIT_EN     = 1,
    parameter int SPLIT_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     mode,
    input  logic                     wr_bus,
    input  logic                     master_valid,
    output logic                     slave_ready,
    output logic                     rd_bus,
    output logic                     slave_valid,
    input  logic                     master_ready,
    output logic                     split,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BUS_DATA_BITS-1:0] mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [BUS_DATA_BITS-1:0] mem_rdata,
    input  logic                     mem_rvalid
);

    localparam logic [3:0] ADDR_LAST = 4'(BUS_ADDR_BITS - 1);
    localparam logic [3:0] DATA_LAST = 4'(BUS_DATA_BITS - 1);
    localparam logic [7:0] THRESH    = 8'(SPLIT_THRESH);

    slave_state_e             state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [BUS_DATA_BITS-1:0] shift_q, shift_d;
    logic                     mode_q, mode_d;
    logic [7:0]               wait_q, wait_d;
    logic                     wr_xfer, rd_xfer;

    assign wr_xfer = master_valid & slave_ready;
    assign rd_xfer = slave_valid & master_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            mode_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            mode_q  <= mode_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        mode_d  = mode_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (wr_xfer) begin
                    addr_d  = {{(ADDR_W-1){1'b0}}, wr_bus};
                    cnt_d   = 4'd1;
                    mode_d  = mode;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // A gap in master_valid mid-frame means the master gave up.
                if (!master_valid) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    addr_d = {addr_q[ADDR_W-2:0], wr_bus};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        wait_d  = '0;
                        state_d = mode_q ? WDATA : MEM_RD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            WDATA: begin
                if (!master_valid) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    shift_d = {shift_q[BUS_DATA_BITS-2:0], wr_bus};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = MEM_WR;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            MEM_WR: begin
                state_d = IDLE;
            end
            MEM_RD: begin
                if (mem_rvalid) begin
                    shift_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = RDATA;
                end else begin
                    // Saturate so a very slow memory never re-triggers mem_re.
                    if (wait_q != 8'hFF) begin
                        wait_d = wait_q + 8'd1;
                    end
                    if ((SPLIT_EN != 0) && (wait_q == THRESH - 8'd1)) begin
                        state_d = SPLIT;
                    end
                end
            end
            SPLIT: begin
                if (mem_rvalid) begin
                    shift_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (rd_xfer) begin
                    shift_d = {shift_q[BUS_DATA_BITS-2:0], 1'b0};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
        split       = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        case (state_q)
            IDLE, ADDR, WDATA: slave_ready = 1'b1;
            MEM_WR:            mem_we      = 1'b1;
            MEM_RD:            mem_re      = (wait_q == 8'd0);
            SPLIT:             split       = 1'b1;
            RDATA: begin
                slave_valid = 1'b1;
                rd_bus      = shift_q[BUS_DATA_BITS-1];
            end
            default: slave_ready = 1'b0;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = shift_q;

endmodule

// File: tb/tb_bb_slave_port.sv
// tb/tb_bb_slave_port.sv - scoreboard bench for bb_slave_port with a bb_slave_bram behind it
module tb_bb_slave_port;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              mode = 1'b0;
    logic              wr_bus = 1'b0;
    logic              master_valid = 1'b0;
    logic              master_ready = 1'b1;
    logic              slave_ready, rd_bus, slave_valid, split;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, mem_rdata;
    logic              mem_we, mem_re, mem_rvalid;
    logic [7:0]        lat = 8'd1;

    bb_slave_port #(.ADDR_W(ADDR_W), .SPLIT_EN(1), .SPLIT_THRESH(4)) dut (
        .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus),
        .master_valid(master_valid), .slave_ready(slave_ready),
        .rd_bus(rd_bus), .slave_valid(slave_valid), .master_ready(master_ready),
        .split(split), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    bb_slave_bram #(.ADDR_W(ADDR_W)) u_mem (
        .clk(clk), .rstn(rstn), .rd_latency(lat), .we(mem_we), .re(mem_re),
        .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata), .rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        int                cyc;
    } wr_exp_t;

    wr_exp_t           wr_q[$];
    logic [ADDR_W-1:0] re_q[$];
    logic [7:0]        rd_q[$];
    wr_exp_t           e_w;
    logic [ADDR_W-1:0] e_a;
    int                re_cyc = 0;
    int                rd_idx = 0;
    int                rd_bytes = 0;
    int                split_rises = 0;
    bit                split_allowed = 0;
    logic              sv_prev = 0, split_prev = 0, rvalid_prev = 0;

    // Monitor: pops expectations whenever the DUT presents a strobe or read bit.
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_we) begin
                if (wr_q.size() == 0) chk("unexpected_mem_we", 1, 0);
                else begin
                    e_w = wr_q.pop_front();
                    chk("we_addr", 32'(mem_addr), 32'(e_w.addr));
                    chk("we_data", 32'(mem_wdata), 32'(e_w.data));
                    chk("we_cycle", cyc, e_w.cyc);
                end
            end
            if (mem_re) begin
                re_cyc = cyc;
                if (re_q.size() == 0) chk("unexpected_mem_re", 1, 0);
                else begin
                    e_a = re_q.pop_front();
                    chk("re_addr", 32'(mem_addr), 32'(e_a));
                end
            end
            if (slave_valid && !sv_prev) chk("rd_latency", cyc - re_cyc, 32'(lat) + 1);
            if (slave_valid) begin
                if (rd_q.size() == 0) chk("unexpected_slave_valid", 1, 0);
                else begin
                    chk("rd_bit", 32'(rd_bus), 32'(rd_q[0][7-rd_idx]));
                    if (master_ready) begin
                        rd_idx++;
                        if (rd_idx == 8) begin
                            void'(rd_q.pop_front());
                            rd_idx = 0;
                            rd_bytes++;
                        end
                    end
                end
            end
            if (split && !split_prev) begin
                split_rises++;
                chk("split_allowed", 32'(split_allowed), 1);
                chk("split_rise_cycle", cyc - re_cyc, 4);
            end
            if (!split && split_prev) chk("split_fall_after_rvalid", 32'(rvalid_prev), 1);
        end
        sv_prev     = slave_valid;
        split_prev  = split;
        rvalid_prev = mem_rvalid;
    end

    bit       stall_en = 0;
    logic [3:0] pat = 4'b1001;
    int       pi = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_en) begin
            master_ready = pat[pi];
            pi = (pi + 1) % 4;
        end else begin
            master_ready = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives nbits of address-then-data back to back; mode flips after the first bit.
    task automatic send(input logic m, input logic [15:0] a, input logic [7:0] d, input int nbits);
        mode = m;
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) wr_bus = a[15-i];
            else        wr_bus = d[23-i];
            master_valid = 1'b1;
            @(posedge clk);
            #1;
            mode = ~m;
        end
        master_valid = 1'b0;
        wr_bus = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        wr_q.push_back('{addr: a[ADDR_W-1:0], data: d, cyc: cyc + 24});
        send(1'b1, a, d, 24);
        tick(3);
    endtask

    task automatic do_read(input string tag, input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        re_q.push_back(a[ADDR_W-1:0]);
        rd_q.push_back(d);
        send(1'b0, a, 8'h00, 16);
        while (rd_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        chk({tag, "_done"}, rd_q.size(), 0);
        tick(2);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_slave_ready"}, 32'(slave_ready), 1);
        chk({tag, "_slave_valid"}, 32'(slave_valid), 0);
        chk({tag, "_rd_bus"}, 32'(rd_bus), 0);
        chk({tag, "_split"}, 32'(split), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_re"}, 32'(mem_re), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    endtask

    int s0, b0;

    initial begin
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick(2);

        // Plain write; slave_ready must drop for exactly the MEM_WR cycle.
        wr_q.push_back('{addr: 12'hA5C, data: 8'h3C, cyc: cyc + 24});
        send(1'b1, 16'h0A5C, 8'h3C, 24);
        @(negedge clk);
        chk("wr_ready_low", 32'(slave_ready), 0);
        @(negedge clk);
        chk("wr_ready_back", 32'(slave_ready), 1);
        tick(3);

        // Read with latency 1, no split expected.
        do_write(16'h0123, 8'hA5);
        lat = 8'd1;
        split_allowed = 0;
        s0 = split_rises;
        b0 = rd_bytes;
        do_read("rd_lat1", 16'h0123, 8'hA5);
        chk("rd_lat1_no_split", split_rises - s0, 0);
        chk("rd_lat1_bytes", rd_bytes - b0, 1);

        // Slow read triggers split.
        do_write(16'h02B7, 8'h5A);
        lat = 8'd10;
        split_allowed = 1;
        s0 = split_rises;
        do_read("rd_split", 16'h02B7, 8'h5A);
        chk("rd_split_count", split_rises - s0, 1);
        split_allowed = 0;
        lat = 8'd1;

        // Aborted address after 6 bits, then a full write.
        send(1'b1, 16'hABCD, 8'h00, 6);
        tick(3);
        do_write(16'h0FFF, 8'h81);

        // Read with master_ready stalls.
        do_write(16'h0040, 8'hC3);
        stall_en = 1;
        b0 = rd_bytes;
        do_read("rd_stall", 16'h0040, 8'hC3);
        stall_en = 0;
        chk("rd_stall_bytes", rd_bytes - b0, 1);
        chk("rd_stall_valid_low", 32'(slave_valid), 0);

        // Reset in the middle of the data phase.
        send(1'b1, 16'h0777, 8'h55, 20);
        rstn = 1'b0;
        #1;
        check_reset("midreset");
        tick(1);
        rstn = 1'b1;
        tick(2);
        do_write(16'h0001, 8'h11);

        tick(5);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("re_q_empty", re_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bb_slave_port.md
Name: bb_slave_port

Overview:
- Target-side endpoint of the bit-serial system bus; the counterpart of the bus master port.
- Deserialises a 16-bit address and, for writes, 8 data bits, all MSB first.
- Issues one access to a local byte-wide memory per transaction. For reads it serialises the 8-bit result back to the master.
- Optionally raises split while a slow read is pending, so the arbiter can release the bus.

Parameters:
- ADDR_W, 12: local address width; the low ADDR_W bits of the 16-bit bus address go to the memory.
- SPLIT_EN, 1: 1 = split support enabled, 0 = split held low.
- SPLIT_THRESH, 4: wait cycles on mem_rvalid before split is asserted (4 to 255).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- mode  in  1  transfer direction from master: 1 = write, 0 = read
- wr_bus  in  1  serial address/write-data bit from master
- master_valid  in  1  master has a valid bit on wr_bus (already gated by address decoder)
- slave_ready  out  1  slave accepts the wr_bus bit this cycle
- rd_bus  out  1  serial read-data bit to master
- slave_valid  out  1  rd_bus bit is valid
- master_ready  in  1  master accepts the rd_bus bit this cycle
- split  out  1  split request to arbiter
- mem_addr  out  ADDR_W  local memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read request strobe
- mem_rdata  in  8  memory read data
- mem_rvalid  in  1  mem_rdata valid; may arrive 1 or more cycles after mem_re

Behaviour:
- Reset (async, rstn low) forces state IDLE and clears all registers and counters.
- Reset values: slave_ready=1, slave_valid=0, rd_bus=0, split=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- A wr_bus bit transfers on a cycle with master_valid & slave_ready. An rd_bus bit transfers on a cycle with slave_valid & master_ready.
- The bit counter is 4 bits. Address bits shift in as addr <= {addr[14:0], wr_bus}.
- State transitions:
  - IDLE: slave_ready=1. The first transferred bit is stored as bit 1, mode is latched, and the block goes to ADDR.
  - ADDR: slave_ready=1. After the 16th bit, go to WDATA if latched mode=1, else MEM_RD. The counter clears.
  - WDATA: slave_ready=1. Shift in 8 bits, then go to MEM_WR.
  - MEM_WR: slave_ready=0. mem_we=1 for exactly one cycle with mem_addr=addr[ADDR_W-1:0]; then IDLE.
  - MEM_RD: slave_ready=0. mem_re pulses on the first cycle only. On mem_rvalid, capture mem_rdata into the shift register and go to RDATA.
    - A wait counter counts cycles without mem_rvalid. If SPLIT_EN and the count reaches SPLIT_THRESH, go to SPLIT.
  - SPLIT: split=1 until mem_rvalid. Capture data, drop split, then go to RDATA.
  - RDATA: slave_valid=1 and rd_bus=shift[7]; shift left on each transfer. After the 8th transfer, go to IDLE.
- Read latency: with mem_rvalid one cycle after mem_re, slave_valid rises 2 cycles after the 16th address bit.
- Abort: master_valid low in ADDR (counter>0) or in WDATA means the master timed out or cleaned up. Return to IDLE with no memory access and the counter cleared; the next bit starts a fresh address.
- mode changing mid-transfer is ignored; only the latched value is used.
- No back-to-back overlap: a new first bit is accepted only in IDLE. Bits arriving in MEM_WR or MEM_RD are held off by slave_ready=0.
- master_ready low in RDATA stalls the shift register with rd_bus held stable.
- mem_rvalid outside MEM_RD/SPLIT is ignored.
- Reset mid-operation drops the transaction and produces no memory strobe.

Decomposition:
- Shared package bb_bus_pkg holds:
  - BUS_ADDR_BITS=16 and BUS_DATA_BITS=8
  - slave state enum {IDLE, ADDR, WDATA, MEM_WR, MEM_RD, SPLIT, RDATA}
- One natural sub-module, bb_slave_bram: a byte memory with a configurable read latency, driving mem_rdata/mem_rvalid. It is used both in the system and in the bench.

Test Plan:
- Write addr 0x0A5C, data 0x3C, slave_ready tied high by master → one mem_we pulse with mem_addr=0xA5C and mem_wdata=0x3C, 24 cycles after the first bit; slave_ready=0 for exactly 1 cycle.
- Read addr 0x0123, memory returns 0xA5 with latency 1 → mem_re pulse with mem_addr=0x123; rd_bus sequence 1,0,1,0,0,1,0,1; split never asserted.
- Read with latency 10, SPLIT_THRESH=4 → split rises 4 cycles after mem_re and falls when mem_rvalid arrives; data 0x5A is then delivered correctly.
- master_valid dropped after 6 address bits, then a full write to 0x0FFF with data 0x81 → no strobe from the aborted attempt; one write to 0xFFF with data 0x81.
- master_ready toggled 1,0,0,1,... during a read of 0xC3 → rd_bus stays stable during stalls; exactly 8 transfers received as 0xC3.
- rstn pulsed low during WDATA → outputs return to reset values immediately, no mem_we; the next write to 0x0001 with data 0x11 completes normally.
